// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_sel;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_ready;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_req;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_sel, mem_rdata,
    output if_rdata, if_ready, ls_rdata, ls_ready, mem_ce, mem_we, mem_addr, mem_wdata, mem_sel,
           stall_req
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_sel, mem_rdata,
    input  if_rdata, if_ready, ls_rdata, ls_ready, mem_ce, mem_we, mem_addr, mem_wdata, mem_sel,
           stall_req
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch (IF) and load/store (LS) ports.
// Define ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority over IF.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              own_ls_q, own_ls_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              ls_ready_q, ls_ready_d;
  logic              any_req, grant_ls;
  assign any_req = bus.if_req | bus.ls_req;
`ifdef ARB_RR_EN
  logic last_ls_q, last_ls_d;
  // on contention the port served last time yields
  assign grant_ls  = bus.ls_req & (~bus.if_req | ~last_ls_q);
  assign last_ls_d = (state_q == IDLE && any_req) ? grant_ls : last_ls_q;
  always_ff @(posedge clk) last_ls_q <= rst ? last_ls_d : 1'b0;
`else
  assign grant_ls = bus.ls_req;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_ls_d    = own_ls_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ready_d  = 1'b0;
    ls_ready_d  = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d     = BUSY;
        cnt_d       = '0;
        own_ls_d    = grant_ls;
        mem_ce_d    = 1'b1;
        mem_we_d    = grant_ls & bus.ls_we;
        mem_addr_d  = grant_ls ? bus.ls_addr : bus.if_addr;
        mem_wdata_d = grant_ls ? bus.ls_wdata : '0;
        mem_sel_d   = grant_ls ? bus.ls_sel : 4'hF;
      end
      BUSY: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) begin
          state_d    = DONE;
          mem_ce_d   = 1'b0;
          mem_we_d   = 1'b0;
          if_ready_d = ~own_ls_q;
          ls_ready_d = own_ls_q;
          if_rdata_d = own_ls_q ? if_rdata_q : bus.mem_rdata;
          ls_rdata_d = (own_ls_q & ~mem_we_q) ? bus.mem_rdata : ls_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_ls_q    <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      ls_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_ls_q    <= own_ls_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_ready_q  <= if_ready_d;
      ls_ready_q  <= ls_ready_d;
    end
  end
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.ls_ready  = ls_ready_q;
  assign bus.stall_req = rst & ((bus.if_req & ~if_ready_q) | (bus.ls_req & ~ls_ready_q));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter at MEM_LAT=1 (u1) and MEM_LAT=3 (u3)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0, vec = 0, bad = 0, c = 0, c1 = 0, c3 = 0;
  bit got;
  logic [31:0] exp_if[$], exp_ls[$], exp3[$], ls_model;
  bit rdy_port[$];
  int rdy_cyc[$];
  logic [31:0] m1 [256];
  logic [31:0] m3 [256];
`ifdef ARB_RR_EN
  localparam logic [3:0] T3_ORD = 4'b0010, T4_ORD = 4'b1010;
`else
  localparam logic [3:0] T3_ORD = 4'b0001, T4_ORD = 4'b0011;
`endif
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memories only present valid data in the last cycle of the enable window
  always @(posedge clk) begin
    c1 <= b1.mem_ce ? c1 + 1 : 0;
    c3 <= b3.mem_ce ? c3 + 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (b1.mem_ce && b1.mem_we && b1.mem_sel[i]) m1[b1.mem_addr[9:2]][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
      if (b3.mem_ce && b3.mem_we && b3.mem_sel[i]) m3[b3.mem_addr[9:2]][8*i +: 8] <= b3.mem_wdata[8*i +: 8];
    end
  end
  assign b1.mem_rdata = (b1.mem_ce && c1 == 0) ? m1[b1.mem_addr[9:2]] : 32'hBAD0BAD0;
  assign b3.mem_rdata = (b3.mem_ce && c3 == 2) ? m3[b3.mem_addr[9:2]] : 32'hBAD0BAD0;
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endfunction
  function automatic void spurious(input string n);
    vec++;
    bad++;
    $display("FAIL %s: ready pulse with nothing outstanding (cycle %0d)", n, cyc);
  endfunction
  always @(negedge clk) begin
    if (b1.if_ready) begin
      rdy_port.push_back(1'b0);
      rdy_cyc.push_back(cyc);
      if (exp_if.size() == 0) spurious("if_ready");
      else chk("if_rdata", b1.if_rdata, exp_if.pop_front());
    end
    if (b1.ls_ready) begin
      rdy_port.push_back(1'b1);
      rdy_cyc.push_back(cyc);
      if (exp_ls.size() == 0) spurious("ls_ready");
      else chk("ls_rdata", b1.ls_rdata, exp_ls.pop_front());
    end
    if (b3.ls_ready) begin
      if (exp3.size() == 0) spurious("u3_ls_ready");
      else chk("u3_ls_rdata", b3.ls_rdata, exp3.pop_front());
    end
    if (b3.if_ready) spurious("u3_if_ready");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy(input bit ls);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = ls ? b1.ls_ready : b1.if_ready;
    end
    if (!seen) begin
      vec++;
      bad++;
      $display("FAIL %s_timeout: ready not seen within 40 cycles", ls ? "ls" : "if");
    end
    tick();
  endtask
  task automatic acc_if(input logic [31:0] a, input logic [31:0] e);
    b1.if_req  = 1'b1;
    b1.if_addr = a;
    exp_if.push_back(e);
    wait_rdy(1'b0);
    b1.if_req = 1'b0;
  endtask
  task automatic acc_ls(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sel, input logic [31:0] e);
    b1.ls_req   = 1'b1;
    b1.ls_we    = we;
    b1.ls_addr  = a;
    b1.ls_wdata = wd;
    b1.ls_sel   = sel;
    if (!we) ls_model = e;
    exp_ls.push_back(ls_model);
    wait_rdy(1'b1);
    b1.ls_req = 1'b0;
  endtask
  task automatic chk_log(input string n, input int base, input int np, input logic [3:0] ep);
    chk({n, "_count"}, rdy_port.size(), np);
    for (int i = 0; i < np && i < rdy_port.size(); i++) begin
      chk({n, "_port"}, 32'(rdy_port[i]), 32'(ep[i]));
      chk({n, "_cycle"}, rdy_cyc[i] - base, 2 + 3 * i);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    b1.if_req = 1'b0; b1.if_addr = '0; b1.ls_req = 1'b0; b1.ls_we = 1'b0;
    b1.ls_addr = '0; b1.ls_wdata = '0; b1.ls_sel = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.ls_req = 1'b0; b3.ls_we = 1'b0;
    b3.ls_addr = '0; b3.ls_wdata = '0; b3.ls_sel = '0;
    ls_model = '0;
    m1[1] = 32'h34011100; m1[2] = 32'h00000013; m1[3] = 32'h00400093;
    m1[32] = 32'hCAFEF00D; m3[16] = 32'h5555AAAA;
    // reset: outputs cleared, stall gated even with a request pending
    b1.if_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", b1.stall_req, 0);
    chk("rst_mem_ce", b1.mem_ce, 0);
    chk("rst_mem_addr", b1.mem_addr, 0);
    chk("rst_if_ready", b1.if_ready, 0);
    chk("rst_if_rdata", b1.if_rdata, 0);
    b1.if_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    // 1: lone fetch
    b1.if_req = 1'b1; b1.if_addr = 32'h4; exp_if.push_back(32'h34011100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_mem_ce", b1.mem_ce, 32'(k == 1));
      chk("t1_if_ready", b1.if_ready, 32'(k == 2));
      if (k == 1) chk("t1_mem_addr", b1.mem_addr, 32'h4);
    end
    tick();
    b1.if_req = 1'b0;
    // 2: store, load back, partial store, load back
    b1.ls_req = 1'b1; b1.ls_we = 1'b1; b1.ls_addr = 32'h40; b1.ls_wdata = 32'hDEADBEEF; b1.ls_sel = 4'hF;
    exp_ls.push_back(ls_model);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_mem_we", b1.mem_we, 32'(k == 1));
      chk("t2_ls_ready", b1.ls_ready, 32'(k == 2));
      if (k == 1) begin
        chk("t2_mem_wdata", b1.mem_wdata, 32'hDEADBEEF);
        chk("t2_mem_sel", b1.mem_sel, 32'hF);
      end
    end
    tick();
    b1.ls_req = 1'b0;
    acc_ls(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEADBEEF);
    acc_ls(1'b1, 32'h40, 32'h11223344, 4'h3, 32'h0);
    acc_ls(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD3344);
    // 3: simultaneous requests
    rdy_port.delete(); rdy_cyc.delete(); c = cyc;
    fork
      acc_ls(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD3344);
      acc_if(32'h8, 32'h00000013);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("t3_stall", b1.stall_req, 32'(k < 5));
      end
    join
    chk_log("t3", c, 2, T3_ORD);
    // 4: both ports requesting back-to-back
    rdy_port.delete(); rdy_cyc.delete(); c = cyc;
    fork
      begin
        acc_if(32'hC, 32'h00400093);
        acc_if(32'h4, 32'h34011100);
      end
      begin
        acc_ls(1'b0, 32'h80, 32'h0, 4'hF, 32'hCAFEF00D);
        acc_ls(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD3344);
      end
    join
    chk_log("t4", c, 4, T4_ORD);
    // request dropped after grant still completes
    b1.ls_req = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 32'h80; b1.ls_sel = 4'hF;
    ls_model = 32'hCAFEF00D;
    exp_ls.push_back(ls_model);
    tick();
    b1.ls_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      got = b1.ls_ready;
    end
    chk("drop_ls_ready", 32'(got), 1);
    tick();
    // 6: reset during BUSY
    b1.if_req = 1'b1; b1.if_addr = 32'h8;
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_ce", b1.mem_ce, 1);
    rst = 1'b0;
    b1.if_req = 1'b0;
    @(negedge clk);
    chk("t6_mem_ce", b1.mem_ce, 0);
    chk("t6_mem_addr", b1.mem_addr, 0);
    chk("t6_if_ready", b1.if_ready, 0);
    chk("t6_if_rdata", b1.if_rdata, 0);
    chk("t6_ls_rdata", b1.ls_rdata, 0);
    chk("t6_stall", b1.stall_req, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    tick();
    rdy_port.delete(); rdy_cyc.delete(); c = cyc;
    acc_if(32'h4, 32'h34011100);
    chk_log("t6", c, 1, 4'b0000);
    // 5: MEM_LAT=3 load
    b3.ls_req = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 32'h40; b3.ls_sel = 4'hF;
    exp3.push_back(32'h5555AAAA);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_mem_ce", b3.mem_ce, 32'(k >= 1 && k <= 3));
      chk("t5_ls_ready", b3.ls_ready, 32'(k == 4));
      if (k >= 1 && k <= 3) chk("t5_mem_addr", b3.mem_addr, 32'h40);
    end
    tick();
    b3.ls_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("left_if", exp_if.size(), 0);
    chk("left_ls", exp_ls.size(), 0);
    chk("left_u3", exp3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
